// File: rtl/scan_drv_pkg.sv
// Shared types for the scan chain driver: FSM states and scan-clock sub-phases.
// CAPT exists only when SCAN_DRV_CAPTURE_EN is defined.
package scan_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
`ifdef SCAN_DRV_CAPTURE_EN
    , ST_CAPT = 3'd1
`endif
  } drv_state_e;

  typedef enum logic [1:0] {
    PH_P1 = 2'd0,
    PH_G1 = 2'd1,
    PH_P2 = 2'd2,
    PH_G2 = 2'd3
  } sub_phase_e;

  function automatic sub_phase_e next_phase(input sub_phase_e ph);
    sub_phase_e nx;
    case (ph)
      PH_P1:   nx = PH_G1;
      PH_G1:   nx = PH_P2;
      PH_P2:   nx = PH_G2;
      PH_G2:   nx = PH_P1;
      default: nx = PH_P1;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/scan_phase_gen.sv
// Scan-clock slot timing: walks P1/G1/P2/G2, PHASE_CYC cycles each, while run is high.
// Parks at P1 with the counter cleared whenever run is low.
module scan_phase_gen
  import scan_drv_pkg::*;
#(
  parameter int PHASE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       run,
  output sub_phase_e phase,
  output sub_phase_e phase_nx,
  output logic       first_cyc,
  output logic       phase_end,
  output logic       slot_end
);

  localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PHASE_CYC - 1);

  sub_phase_e    ph_r;
  sub_phase_e    ph_nx_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nx_s;

  // Next sub-phase and in-phase cycle count
  always_comb begin
    ph_nx_s  = PH_P1;
    cnt_nx_s = '0;
    if (run) begin
      if (cnt_r == LAST_CNT) begin
        cnt_nx_s = '0;
        ph_nx_s  = next_phase(ph_r);
      end else begin
        cnt_nx_s = cnt_r + CW'(1);
        ph_nx_s  = ph_r;
      end
    end else begin
      cnt_nx_s = '0;
      ph_nx_s  = PH_P1;
    end
  end

  // Phase and counter registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ph_r  <= PH_P1;
      cnt_r <= '0;
    end else begin
      ph_r  <= ph_nx_s;
      cnt_r <= cnt_nx_s;
    end
  end

  assign phase     = ph_r;
  assign phase_nx  = ph_nx_s;
  assign first_cyc = (cnt_r == '0);
  assign phase_end = (cnt_r == LAST_CNT);
  assign slot_end  = (ph_r == PH_G2) && (cnt_r == LAST_CNT);

endmodule

// File: rtl/scan_chain_driver.sv
// Two-phase scan chain driver: optional capture slot, MSB-first shift, update strobe, done.
// Capture support is compiled in with SCAN_DRV_CAPTURE_EN.
module scan_chain_driver
  import scan_drv_pkg::*;
#(
  parameter int NUM_SCAN_BITS = 523,
  parameter int PHASE_CYC     = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_capture,
  input  logic [NUM_SCAN_BITS-1:0] data_in,
  output logic [NUM_SCAN_BITS-1:0] data_out,
  output logic                     done,
  output logic                     SC_CLK1,
  output logic                     SC_CLK2,
  output logic                     SC_IN,
  output logic                     SC_UPDT,
  output logic                     SC_CAPTURE,
  input  logic                     SC_OUT
);

  localparam int BW = $clog2(NUM_SCAN_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_SCAN_BITS - 1);

  drv_state_e               state_r, state_nx_s;
  sub_phase_e               phase_s, phase_nx_s;
  logic                     first_cyc_s, phase_end_s, slot_end_s;
  logic                     run_s, accept_s, sample_s, clocking_s;
  logic [NUM_SCAN_BITS-1:0] tx_r, tx_nx_s, rx_r, data_out_r;
  logic [BW-1:0]            bit_cnt_r;
  logic sc_clk1_r, sc_clk2_r, sc_in_r, sc_updt_r, done_r, cmd_ready_r;
  logic sc_clk1_nx_s, sc_clk2_nx_s, sc_in_nx_s, sc_updt_nx_s, done_nx_s, ready_nx_s;

  assign accept_s = cmd_valid && cmd_ready_r;
  assign run_s    = (state_r != ST_IDLE) && (state_r != ST_DONE);
  assign sample_s = (state_r == ST_SHIFT) && (phase_s == PH_P1) && first_cyc_s;

  scan_phase_gen #(.PHASE_CYC(PHASE_CYC)) u_phase (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .run       (run_s),
    .phase     (phase_s),
    .phase_nx  (phase_nx_s),
    .first_cyc (first_cyc_s),
    .phase_end (phase_end_s),
    .slot_end  (slot_end_s)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
`ifdef SCAN_DRV_CAPTURE_EN
          state_nx_s = cmd_capture ? ST_CAPT : ST_SHIFT;
`else
          state_nx_s = ST_SHIFT;
`endif
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
`ifdef SCAN_DRV_CAPTURE_EN
      ST_CAPT: begin
        if (slot_end_s) state_nx_s = ST_SHIFT;
        else            state_nx_s = ST_CAPT;
      end
`endif
      ST_SHIFT: begin
        if (slot_end_s && (bit_cnt_r == LAST_BIT)) state_nx_s = ST_UPDATE;
        else                                       state_nx_s = ST_SHIFT;
      end
      ST_UPDATE: begin
        if ((phase_s == PH_G1) && phase_end_s) state_nx_s = ST_DONE;
        else                                   state_nx_s = ST_UPDATE;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Transmit word: load on accept, advance one bit per completed shift slot
  always_comb begin
    tx_nx_s = tx_r;
    if (accept_s) begin
      tx_nx_s = data_in;
    end else if ((state_r == ST_SHIFT) && slot_end_s) begin
      tx_nx_s = {tx_r[NUM_SCAN_BITS-2:0], 1'b0};
    end else begin
      tx_nx_s = tx_r;
    end
  end

  // Output decode from next state/phase so every pin comes straight off a flop
  always_comb begin
`ifdef SCAN_DRV_CAPTURE_EN
    clocking_s = (state_nx_s == ST_SHIFT) || (state_nx_s == ST_CAPT);
`else
    clocking_s = (state_nx_s == ST_SHIFT);
`endif
    sc_clk1_nx_s = 1'b0;
    sc_clk2_nx_s = 1'b0;
    if (clocking_s) begin
      sc_clk1_nx_s = (phase_nx_s == PH_P1);
      sc_clk2_nx_s = (phase_nx_s == PH_P2);
    end else begin
      sc_clk1_nx_s = 1'b0;
      sc_clk2_nx_s = 1'b0;
    end
    sc_in_nx_s   = (state_nx_s == ST_SHIFT) ? tx_nx_s[NUM_SCAN_BITS-1] : 1'b0;
    sc_updt_nx_s = (state_nx_s == ST_UPDATE) && (phase_nx_s == PH_P1);
    done_nx_s    = (state_nx_s == ST_DONE);
    ready_nx_s   = (state_nx_s == ST_IDLE);
  end

  // Datapath: shift-out word, receive word, bit counter, result latch
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx_r       <= '0;
      rx_r       <= '0;
      bit_cnt_r  <= '0;
      data_out_r <= '0;
    end else begin
      tx_r <= tx_nx_s;
      if (accept_s) begin
        bit_cnt_r <= '0;
      end else if ((state_r == ST_SHIFT) && slot_end_s) begin
        bit_cnt_r <= bit_cnt_r + BW'(1);
      end
      if (sample_s) begin
        rx_r <= {rx_r[NUM_SCAN_BITS-2:0], SC_OUT};
      end
      if ((state_r == ST_UPDATE) && (state_nx_s == ST_DONE)) begin
        data_out_r <= rx_r;
      end
    end
  end

  // Registered scan pins and handshake outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sc_clk1_r   <= 1'b0;
      sc_clk2_r   <= 1'b0;
      sc_in_r     <= 1'b0;
      sc_updt_r   <= 1'b0;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      sc_clk1_r   <= sc_clk1_nx_s;
      sc_clk2_r   <= sc_clk2_nx_s;
      sc_in_r     <= sc_in_nx_s;
      sc_updt_r   <= sc_updt_nx_s;
      done_r      <= done_nx_s;
      cmd_ready_r <= ready_nx_s;
    end
  end

`ifdef SCAN_DRV_CAPTURE_EN
  logic sc_capture_r;

  // Capture select follows the CAPT slot
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sc_capture_r <= 1'b0;
    end else begin
      sc_capture_r <= (state_nx_s == ST_CAPT);
    end
  end

  assign SC_CAPTURE = sc_capture_r;
`else
  logic unused_capture_s;
  assign unused_capture_s = cmd_capture;
  assign SC_CAPTURE       = 1'b0;
`endif

  assign SC_CLK1   = sc_clk1_r;
  assign SC_CLK2   = sc_clk2_r;
  assign SC_IN     = sc_in_r;
  assign SC_UPDT   = sc_updt_r;
  assign done      = done_r;
  assign cmd_ready = cmd_ready_r;
  assign data_out  = data_out_r;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench for scan_chain_driver (8-bit chain model, PHASE_CYC 1 and 3).
// Capture expectations follow SCAN_DRV_CAPTURE_EN.
module tb_scan_chain_driver;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       cmd_valid = 1'b0, cmd_capture = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       cmd_ready, done;
  logic [7:0] data_out;
  logic       SC_CLK1, SC_CLK2, SC_IN, SC_UPDT, SC_CAPTURE, SC_OUT;

  logic       cmd_valid3 = 1'b0;
  logic [7:0] data_in3 = 8'h00;
  logic       cmd_ready3, done3;
  logic [7:0] data_out3;
  logic       sc_clk1_3, sc_clk2_3, sc_in_3, sc_updt_3, sc_capture_3;

  logic [7:0] l1 = 8'h00, l2 = 8'h00, upd = 8'h00, par_in = 8'h00;
  logic [7:0] sin_hist = 8'h00;
  logic       p1 = 1'b0, p2 = 1'b0, pu = 1'b0, q1 = 1'b0, q2 = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  int n_c1 = 0, n_c2 = 0, n_up = 0, n_upc = 0, n_cap = 0, n_done = 0, n_ovl = 0;
  int hi1 = 0, hi2 = 0, n3_c1 = 0, n3_c2 = 0, bad3 = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  scan_chain_driver #(.NUM_SCAN_BITS(8), .PHASE_CYC(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_capture(cmd_capture), .data_in(data_in), .data_out(data_out), .done(done),
    .SC_CLK1(SC_CLK1), .SC_CLK2(SC_CLK2), .SC_IN(SC_IN), .SC_UPDT(SC_UPDT),
    .SC_CAPTURE(SC_CAPTURE), .SC_OUT(SC_OUT)
  );

  scan_chain_driver #(.NUM_SCAN_BITS(8), .PHASE_CYC(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_capture(1'b0), .data_in(data_in3), .data_out(data_out3), .done(done3),
    .SC_CLK1(sc_clk1_3), .SC_CLK2(sc_clk2_3), .SC_IN(sc_in_3), .SC_UPDT(sc_updt_3),
    .SC_CAPTURE(sc_capture_3), .SC_OUT(sc_in_3)
  );

  // Two-phase LSSD chain model: L1 loads on SC_CLK1, L2 copies L1 on SC_CLK2
  assign SC_OUT = l2[7];
  always @(posedge CLK) begin
    if (SC_CLK1) l1 <= SC_CAPTURE ? par_in : {l2[6:0], SC_IN};
    if (SC_CLK2) l2 <= l1;
    if (SC_UPDT) upd <= l2;
  end

  // Pin monitor, sampled on the falling edge
  always @(negedge CLK) begin
    p1 <= SC_CLK1; p2 <= SC_CLK2; pu <= SC_UPDT;
    if (SC_CLK1 && !p1) begin
      n_c1 <= n_c1 + 1;
      sin_hist <= {sin_hist[6:0], SC_IN};
    end
    if (SC_CLK2 && !p2) n_c2 <= n_c2 + 1;
    if (SC_UPDT && !pu) n_up <= n_up + 1;
    if (SC_UPDT) n_upc <= n_upc + 1;
    if (SC_CAPTURE) n_cap <= n_cap + 1;
    if (done) n_done <= n_done + 1;
    n_ovl <= n_ovl + int'((SC_CLK1 && SC_CLK2) || (SC_UPDT && (SC_CLK1 || SC_CLK2)))
                   + int'((sc_clk1_3 && sc_clk2_3) || (sc_updt_3 && (sc_clk1_3 || sc_clk2_3)));
    if (sc_clk1_3) hi1 <= hi1 + 1;
    else begin
      if (hi1 != 0) begin n3_c1 <= n3_c1 + 1; if (hi1 != 3) bad3 <= bad3 + 1; end
      hi1 <= 0;
    end
    if (sc_clk2_3) hi2 <= hi2 + 1;
    else begin
      if (hi2 != 0) begin n3_c2 <= n3_c2 + 1; if (hi2 != 3) bad3 <= bad3 + 1; end
      hi2 <= 0;
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic start_cmd(input logic [7:0] d, input logic cap, output int acc);
    int w = 0;
    while (!cmd_ready && w < 100) begin step(); w++; end
    checks++;
    if (!cmd_ready) begin errors++; $display("FAIL start_ready got %b want 1", cmd_ready); end
    cmd_valid = 1'b1; data_in = d; cmd_capture = cap;
    acc = cyc + 1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int acc, output int lat);
    int w = 0;
    while (!done && w < 400) begin step(); w++; end
    checks++;
    if (!done) begin
      errors++; $display("FAIL done_timeout no done within 400 cycles");
      lat = -1;
    end else lat = cyc - acc;
    step();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) step();
    checks += 8;
    if (SC_CLK1 !== 1'b0)    begin errors++; $display("FAIL rst_clk1 got %b want 0", SC_CLK1); end
    if (SC_CLK2 !== 1'b0)    begin errors++; $display("FAIL rst_clk2 got %b want 0", SC_CLK2); end
    if (SC_IN !== 1'b0)      begin errors++; $display("FAIL rst_in got %b want 0", SC_IN); end
    if (SC_UPDT !== 1'b0)    begin errors++; $display("FAIL rst_updt got %b want 0", SC_UPDT); end
    if (SC_CAPTURE !== 1'b0) begin errors++; $display("FAIL rst_capture got %b want 0", SC_CAPTURE); end
    if (done !== 1'b0)       begin errors++; $display("FAIL rst_done got %b want 0", done); end
    if (data_out !== 8'h00)  begin errors++; $display("FAIL rst_data_out got %h want 00", data_out); end
    if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int acc, lat, b1, b2, bu, buc, bc, bd, bo;
    b1 = n_c1; b2 = n_c2; bu = n_up; buc = n_upc; bc = n_cap; bd = n_done; bo = n_ovl;
    start_cmd(8'hA5, 1'b0, acc);
    wait_done(acc, lat);
    checks += 11;
    if (n_c1 - b1 !== 8)     begin errors++; $display("FAIL basic_clk1 got %0d want 8", n_c1 - b1); end
    if (n_c2 - b2 !== 8)     begin errors++; $display("FAIL basic_clk2 got %0d want 8", n_c2 - b2); end
    if (n_up - bu !== 1)     begin errors++; $display("FAIL basic_updt_pulses got %0d want 1", n_up - bu); end
    if (n_upc - buc !== 1)   begin errors++; $display("FAIL basic_updt_cycles got %0d want 1", n_upc - buc); end
    if (n_cap - bc !== 0)    begin errors++; $display("FAIL basic_capture got %0d want 0", n_cap - bc); end
    if (sin_hist !== 8'hA5)  begin errors++; $display("FAIL basic_sc_in_seq got %h want a5", sin_hist); end
    if (lat !== 34)          begin errors++; $display("FAIL basic_latency got %0d want 34", lat); end
    if (upd !== 8'hA5)       begin errors++; $display("FAIL basic_update_latch got %h want a5", upd); end
    if (data_out !== 8'h00)  begin errors++; $display("FAIL basic_data_out got %h want 00", data_out); end
    if (n_done - bd !== 1)   begin errors++; $display("FAIL basic_done_cycles got %0d want 1", n_done - bd); end
    if (n_ovl - bo !== 0)    begin errors++; $display("FAIL basic_overlap got %0d want 0", n_ovl - bo); end
  endtask

  task automatic test_readback();
    int acc, lat;
    start_cmd(8'h00, 1'b0, acc);
    wait_done(acc, lat);
    checks += 3;
    if (data_out !== 8'hA5) begin errors++; $display("FAIL readback_data_out got %h want a5", data_out); end
    if (upd !== 8'h00)      begin errors++; $display("FAIL readback_update got %h want 00", upd); end
    if (lat !== 34)         begin errors++; $display("FAIL readback_latency got %0d want 34", lat); end
  endtask

  task automatic test_capture();
    int acc, lat, bc, exp_cap, exp_lat;
    logic [7:0] exp_do;
`ifdef SCAN_DRV_CAPTURE_EN
    exp_cap = 4; exp_lat = 38; exp_do = 8'h3C;
`else
    exp_cap = 0; exp_lat = 34; exp_do = 8'h00;
`endif
    par_in = 8'h3C;
    bc = n_cap;
    start_cmd(8'h5A, 1'b1, acc);
    wait_done(acc, lat);
    checks += 4;
    if (n_cap - bc !== exp_cap) begin errors++; $display("FAIL capture_cycles got %0d want %0d", n_cap - bc, exp_cap); end
    if (data_out !== exp_do)    begin errors++; $display("FAIL capture_data_out got %h want %h", data_out, exp_do); end
    if (lat !== exp_lat)        begin errors++; $display("FAIL capture_latency got %0d want %0d", lat, exp_lat); end
    if (upd !== 8'h5A)          begin errors++; $display("FAIL capture_update got %h want 5a", upd); end
  endtask

  task automatic test_busy();
    int acc, lat, bd;
    logic [7:0] exp_do;
`ifdef SCAN_DRV_CAPTURE_EN
    exp_do = 8'h5A;
`else
    exp_do = 8'h5A;
`endif
    bd = n_done;
    start_cmd(8'hC3, 1'b0, acc);
    cmd_valid = 1'b1; data_in = 8'hFF;
    repeat (10) step();
    cmd_valid = 1'b0;
    wait_done(acc, lat);
    repeat (10) step();
    checks += 5;
    if (n_done - bd !== 1)  begin errors++; $display("FAIL busy_done_count got %0d want 1", n_done - bd); end
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL busy_ready got %b want 1", cmd_ready); end
    if (upd !== 8'hC3)      begin errors++; $display("FAIL busy_update got %h want c3", upd); end
    if (lat !== 34)         begin errors++; $display("FAIL busy_latency got %0d want 34", lat); end
    if (data_out !== exp_do) begin errors++; $display("FAIL busy_data_out got %h want %h", data_out, exp_do); end
  endtask

  task automatic test_midreset();
    int acc, bd, bu;
    bd = n_done; bu = n_upc;
    start_cmd(8'hFF, 1'b0, acc);
    repeat (13) step();
    RST_N = 1'b0;
    step();
    checks += 6;
    if ({SC_CLK1, SC_CLK2, SC_IN, SC_UPDT, SC_CAPTURE} !== 5'b00000)
      begin errors++; $display("FAIL midrst_sc_pins got %b want 00000", {SC_CLK1, SC_CLK2, SC_IN, SC_UPDT, SC_CAPTURE}); end
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", cmd_ready); end
    if (done !== 1'b0)      begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data_out got %h want 00", data_out); end
    RST_N = 1'b1;
    repeat (60) step();
    if (n_done - bd !== 0)  begin errors++; $display("FAIL midrst_no_done got %0d want 0", n_done - bd); end
    if (n_upc - bu !== 0)   begin errors++; $display("FAIL midrst_no_updt got %0d want 0", n_upc - bu); end
  endtask

  task automatic test_nonoverlap();
    int acc, lat, w, b1, b2, bb, bo;
    b1 = n3_c1; b2 = n3_c2; bb = bad3; bo = n_ovl;
    data_in3 = 8'($urandom);
    cmd_valid3 = 1'b1;
    acc = cyc + 1;
    step();
    cmd_valid3 = 1'b0;
    w = 0;
    while (!done3 && w < 400) begin step(); w++; end
    lat = done3 ? (cyc - acc) : -1;
    step();
    checks += 5;
    if (lat !== 102)       begin errors++; $display("FAIL p3_latency got %0d want 102", lat); end
    if (n3_c1 - b1 !== 8)  begin errors++; $display("FAIL p3_clk1_pulses got %0d want 8", n3_c1 - b1); end
    if (n3_c2 - b2 !== 8)  begin errors++; $display("FAIL p3_clk2_pulses got %0d want 8", n3_c2 - b2); end
    if (bad3 - bb !== 0)   begin errors++; $display("FAIL p3_high_time got %0d bad pulses want 0", bad3 - bb); end
    if (n_ovl - bo !== 0)  begin errors++; $display("FAIL p3_overlap got %0d want 0", n_ovl - bo); end
  endtask

  initial begin
    step();
    test_reset();
    test_basic();
    test_readback();
    test_capture();
    test_busy();
    test_midreset();
    test_nonoverlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_chain_driver.md
SCAN_CHAIN_DRIVER -- requirements
Module: scan_chain_driver

Interface
REQ-001 SHALL have parameter NUM_SCAN_BITS, default 523, meaning the scan chain length in bits.
REQ-002 SHALL have parameter PHASE_CYC, default 2, meaning CLK cycles per scan-clock phase; legal range is 1 or more.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: request to run one scan operation.
REQ-006 SHALL have port cmd_ready, output, 1 bit: driver idle; a command is accepted when cmd_valid and cmd_ready are both high on an edge.
REQ-007 SHALL have port cmd_capture, input, 1 bit: when high, a capture pulse runs before the shift; sampled at accept.
REQ-008 SHALL have port data_in, input, NUM_SCAN_BITS bits: word to shift in; sampled at accept.
REQ-009 SHALL have port data_out, output, NUM_SCAN_BITS bits: word shifted out; valid from done until the next accept.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking operation complete.
REQ-011 SHALL have ports SC_CLK1 and SC_CLK2, outputs, 1 bit each: non-overlapping two-phase scan clocks.
REQ-012 SHALL have ports SC_IN, SC_UPDT and SC_CAPTURE, outputs, 1 bit each: scan data, update strobe and capture select.
REQ-013 SHALL have port SC_OUT, input, 1 bit: scan chain serial output.

Function
REQ-014 SHALL use FSM states IDLE, CAPT, SHIFT, UPDATE and DONE.
REQ-015 SHALL walk each scan-clock slot through four sub-phases of PHASE_CYC cycles each: P1 (SC_CLK1 high), G1 (both clocks low), P2 (SC_CLK2 high), G2 (both clocks low).
REQ-016 SHALL transition from IDLE on accept to CAPT if cmd_capture is high, otherwise to SHIFT; cmd_ready SHALL be high only in IDLE.
REQ-017 SHALL, in CAPT, hold SC_CAPTURE high for one full slot (4*PHASE_CYC cycles) and then go to SHIFT.
REQ-018 SHALL, in SHIFT, run NUM_SCAN_BITS slots, driving SC_IN with data_in bits MSB first; SC_IN is stable for the whole slot.
REQ-019 SHALL sample SC_OUT at the end of the first cycle of P1 in every SHIFT slot, storing samples MSB first, so the first sample lands in data_out[NUM_SCAN_BITS-1].
REQ-020 SHALL, in UPDATE, drive SC_UPDT high for PHASE_CYC cycles, then low for PHASE_CYC cycles, then go to DONE.
REQ-021 SHALL, in DONE, pulse done for 1 cycle and return to IDLE.
REQ-022 SHALL make the latency from the accept edge to the done-high cycle exactly (cmd_capture ? 4 : 0)*PHASE_CYC + 4*PHASE_CYC*NUM_SCAN_BITS + 2*PHASE_CYC cycles.
REQ-023 SHALL never have SC_CLK1 and SC_CLK2 high in the same cycle, and SHALL never assert SC_UPDT while either scan clock is high.
REQ-024 SHALL ignore cmd_valid while busy, with no queuing.
REQ-025 SHALL keep the bit counter wide enough for NUM_SCAN_BITS with no wrap; SHIFT ends after exactly NUM_SCAN_BITS slots.

Reset
REQ-026 SHALL, on RST_N low at an edge, force on the next cycle: state IDLE; SC_CLK1, SC_CLK2, SC_IN, SC_UPDT, SC_CAPTURE and done at 0; data_out at 0; cmd_ready at 1.
REQ-027 SHALL, on reset during an operation, abort the operation with no done pulse and no SC_UPDT.

Configuration
REQ-028 SHALL, with macro SCAN_DRV_CAPTURE_EN defined, honour cmd_capture as specified above.
REQ-029 SHALL, with SCAN_DRV_CAPTURE_EN undefined, ignore cmd_capture, tie SC_CAPTURE to 0, omit the CAPT state, and use latency 4*PHASE_CYC*NUM_SCAN_BITS + 2*PHASE_CYC.

Structure
REQ-030 SHALL place the FSM state enum and the sub-phase encoding (P1/G1/P2/G2) in shared package scan_drv_pkg.
REQ-031 SHALL implement the phase and slot timing in sub-module scan_phase_gen (PHASE_CYC counter, sub-phase output, slot-end strobe), while the FSM, shift register and bit counter stay in scan_chain_driver.

Verification (NUM_SCAN_BITS=8 and PHASE_CYC=1 unless stated; chain model is an 8-bit two-phase shift register with par_in and update latch)
REQ-032 SHALL verify reset: hold RST_N low 3 cycles -> all SC_* outputs 0, done 0, data_out 0, cmd_ready 1.
REQ-033 SHALL verify a basic shift: data_in=8'hA5, cmd_capture=0 -> SC_IN sequence 1,0,1,0,0,1,0,1, exactly 8 SC_CLK1 and 8 SC_CLK2 pulses, one 1-cycle SC_UPDT, done 34 cycles after accept, model update latch = 8'hA5.
REQ-034 SHALL verify readback: a second command with data_in=8'h00 after 8'hA5 -> data_out=8'hA5.
REQ-035 SHALL verify capture: model par_in=8'h3C, cmd_capture=1 -> SC_CAPTURE high for 4 cycles, data_out=8'h3C, done 38 cycles after accept; with the macro undefined, SC_CAPTURE stays 0 and the latency is 34.
REQ-036 SHALL verify non-overlap: PHASE_CYC=3 with random data -> the assertion "SC_CLK1 and SC_CLK2 never both high" holds, and each clock high time is exactly 3 cycles.
REQ-037 SHALL verify reset mid-operation: RST_N low during slot 4 of SHIFT -> next cycle all SC_* outputs 0 and cmd_ready 1, and no done or SC_UPDT follows.
